// File: rtl/sobel_filter_if.sv
// FIFO-side handshake bundle for the Sobel stage: the pop side of the blur
// output FIFO and the push side of the FIFO feeding non-maximum suppression.
interface sobel_filter_if;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;

  // Filter side: pops the input FIFO and pushes the output FIFO.
  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  // FIFO side: the environment around the filter.
  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );
endinterface

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge-magnitude stage. Pops blurred pixels in raster
// order, keeps two rows plus three pixels in a shift-register line buffer and
// pushes one saturated |gx|+|gy| magnitude per input pixel. Border pixels
// produce 0, which also hides stale data and flush zeros.
module sobel_filter #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input logic            clock,
  input logic            reset,
  sobel_filter_if.master fifo
);

  localparam int LB_LEN = 2 * IMG_WIDTH + 3;
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int PW     = $clog2(NPIX);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    lb [LB_LEN];
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          out_valid;
  logic [7:0]    out_data;

  logic          slot_free, adv;
  logic          last_fill, last_run, last_flush;
  logic [7:0]    new_byte;
  logic [7:0]    win [3][3];
  logic [9:0]    gx_pos, gx_neg, gy_pos, gy_neg;
  logic [9:0]    ax, ay;
  logic [10:0]   mag_sum, mag;
  logic          border;
  logic [7:0]    result;

  // pix_cnt counts pops within the frame in FILL/RUN and restarts at 0 to
  // count the zero-shifts of FLUSH.
  assign last_fill  = (pix_cnt == PW'(IMG_WIDTH));
  assign last_run   = (pix_cnt == PW'(NPIX - 1));
  assign last_flush = (pix_cnt == PW'(IMG_WIDTH));

  // State register.
  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of its neighbours; = here would create order-dependent
  // simulation and mismatching synthesis.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state: frame phases move only on an advance.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (adv) begin
      case (state)
        FILL:    if (last_fill)  state_nxt = RUN;
        RUN:     if (last_run)   state_nxt = FLUSH;
        FLUSH:   if (last_flush) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Outputs: advance/pop decision and the FIFO-facing strobes. The advance is
  // held off while reset is asserted so no pixel is popped and discarded.
  always_comb begin
    slot_free      = ~out_valid | ~fifo.out_full;
    adv            = reset & slot_free & ((state == FLUSH) | ~fifo.in_empty);
    fifo.in_rd_en  = adv & (state != FLUSH);
    new_byte       = (state == FLUSH) ? 8'h00 : fifo.in_dout;
    fifo.out_wr_en = out_valid & ~fifo.out_full;
    fifo.out_din   = out_data;
  end

  // Line buffer shift: oldest byte at index 0, newest at the tail.
  // NOTE: the line buffer has no reset; border masking guarantees its stale
  // contents never reach the output, and leaving it unreset lets it map onto
  // plain storage instead of resettable flops.
  always_ff @(posedge clock) begin
    if (adv) begin
      for (int i = 0; i < LB_LEN - 1; i++) lb[i] <= lb[i + 1];
      lb[LB_LEN - 1] <= new_byte;
    end
  end

  // Frame counters: pop count and the row/column of the next output's center.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
      col     <= '0;
      row     <= '0;
    end else if (adv) begin
      case (state)
        FILL: pix_cnt <= pix_cnt + 1'b1;
        RUN: begin
          pix_cnt <= last_run ? '0 : pix_cnt + 1'b1;
          if (col == CW'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        FLUSH: begin
          if (last_flush) begin
            pix_cnt <= '0;
            col     <= '0;
            row     <= '0;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
            if (col == CW'(IMG_WIDTH - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: pix_cnt <= '0;
      endcase
    end
  end

  // Sobel kernel on the post-shift window, so the result can be registered in
  // the same cycle as the pop that completes it.
  always_comb begin
    win[0][0] = lb[1];
    win[0][1] = lb[2];
    win[0][2] = lb[3];
    win[1][0] = lb[IMG_WIDTH + 1];
    win[1][1] = lb[IMG_WIDTH + 2];
    win[1][2] = lb[IMG_WIDTH + 3];
    win[2][0] = lb[2 * IMG_WIDTH + 1];
    win[2][1] = lb[2 * IMG_WIDTH + 2];
    win[2][2] = new_byte;

    gx_pos = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
    gx_neg = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
    gy_pos = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
    gy_neg = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};

    // |a-b| taken directly from the unsigned halves avoids a signed negate.
    ax = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
    ay = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;

    mag_sum = {1'b0, ax} + {1'b0, ay};
    mag     = mag_sum >> 1;

    border = (row == '0) || (row == RW'(IMG_HEIGHT - 1)) ||
             (col == '0) || (col == CW'(IMG_WIDTH - 1));

    if (border)               result = 8'h00;
    else if (mag > 11'd255)   result = 8'hFF;
    else                      result = mag[7:0];
  end

  // Output slot: load on a producing advance, drain on a push; both in the
  // same cycle give back-to-back pushes without a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (adv && (state != FILL)) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (fifo.out_wr_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter on an 8x6 image: reset values, flat, ramp,
// step, randomly stalled random frame, mid-frame reset and back-to-back frames,
// compared against a frame-level reference computed from the whole image.
module tb_sobel_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sobel_filter_if fifo ();

  sobel_filter #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fifo (fifo)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] img [N];
  logic [7:0] src [$];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int         pop_cyc [$];
  int         push_cyc [$];
  int         viol;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r * W + c]);
  endfunction

  function automatic int got_at(input int i);
    return (i < got.size()) ? int'(got[i]) : -1;
  endfunction

  // Reference magnitude for every pixel of img, appended in raster order.
  task automatic add_golden();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int gx, gy, m;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          m = 0;
        end else begin
          gx = px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1)
             - px(r-1, c-1) - 2*px(r, c-1) - px(r+1, c-1);
          gy = px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1)
             - px(r-1, c-1) - 2*px(r-1, c) - px(r-1, c+1);
          m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
          if (m > 255) m = 255;
        end
        exp_q.push_back(8'(m));
      end
    end
  endtask

  task automatic load_src();
    for (int i = 0; i < N; i++) src.push_back(img[i]);
  endtask

  // Drives both FIFOs cycle by cycle until `target` pushes, the cycle budget,
  // or (if nonzero) `stop_pops` pops. Entered and left at posedge+1.
  task automatic run(input int target, input int max_cyc, input int p_empty,
                     input int p_full, input int stop_pops);
    int         cyc;
    logic       rd, wr;
    logic [7:0] d;
    cyc = 0;
    got.delete();
    pop_cyc.delete();
    push_cyc.delete();
    viol = 0;
    while (got.size() < target && cyc < max_cyc &&
           !(stop_pops > 0 && pop_cyc.size() >= stop_pops)) begin
      fifo.in_empty = (src.size() == 0) || ($urandom_range(99) < p_empty);
      fifo.in_dout  = (src.size() != 0) ? src[0] : 8'h00;
      fifo.out_full = ($urandom_range(99) < p_full);
      @(negedge clock);
      rd = fifo.in_rd_en;
      wr = fifo.out_wr_en;
      d  = fifo.out_din;
      if (rd && fifo.in_empty) viol++;
      if (wr && fifo.out_full) viol++;
      @(posedge clock);
      if (rd) begin
        void'(src.pop_front());
        pop_cyc.push_back(cyc);
      end
      if (wr) begin
        got.push_back(d);
        push_cyc.push_back(cyc);
      end
      #1;
      cyc++;
    end
    fifo.in_empty = 1'b1;
    fifo.out_full = 1'b0;
  endtask

  task automatic compare(input string tag);
    int m;
    m = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) m++;
    check({tag, "_count"}, got.size(), exp_q.size());
    check({tag, "_mismatches"}, m, 0);
  endtask

  initial begin
    int extra;

    // Reset values, with the input FIFO offering data to prove no pop.
    fifo.in_empty = 1'b0;
    fifo.in_dout  = 8'h55;
    fifo.out_full = 1'b0;
    @(negedge clock);
    check("rst_in_rd_en", fifo.in_rd_en, 0);
    check("rst_out_wr_en", fifo.out_wr_en, 0);
    check("rst_out_din", fifo.out_din, 0);
    fifo.in_empty = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("idle_in_rd_en", fifo.in_rd_en, 0);
    @(posedge clock);
    #1;

    // Flat 0x7F frame: all zeros, first push 10 cycles after first pop.
    for (int i = 0; i < N; i++) img[i] = 8'h7F;
    exp_q.delete(); add_golden(); load_src();
    run(N, 500, 0, 0, 0);
    compare("flat");
    check("flat_pops", pop_cyc.size(), N);
    check("flat_latency", (pop_cyc.size() > 0 && push_cyc.size() > 0) ?
          push_cyc[0] - pop_cyc[0] : -1, 10);

    // Horizontal ramp 10*col: interior 40.
    for (int i = 0; i < N; i++) img[i] = 8'(10 * (i % W));
    exp_q.delete(); add_golden(); load_src();
    run(N, 500, 0, 0, 0);
    compare("ramp");
    check("ramp_r1c1", got_at(1 * W + 1), 40);
    check("ramp_r4c6", got_at(4 * W + 6), 40);
    check("ramp_r0c3", got_at(0 * W + 3), 0);
    check("ramp_r2c7", got_at(2 * W + 7), 0);

    // Vertical step at col 4: interior cols 3 and 4 saturate to 255.
    for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? 8'h00 : 8'hFF;
    exp_q.delete(); add_golden(); load_src();
    run(N, 500, 0, 0, 0);
    compare("step");
    check("step_r1c3", got_at(1 * W + 3), 255);
    check("step_r2c4", got_at(2 * W + 4), 255);
    check("step_r3c2", got_at(3 * W + 2), 0);
    check("step_r4c5", got_at(4 * W + 5), 0);
    check("step_r5c4", got_at(5 * W + 4), 0);

    // Random frame with 30% input starvation and 30% output back-pressure.
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
    exp_q.delete(); add_golden(); load_src();
    run(N, 3000, 30, 30, 0);
    compare("rand");
    check("rand_protocol_violations", viol, 0);

    // Mid-frame reset after 20 pops, then a fresh flat frame.
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
    load_src();
    run(N, 500, 0, 0, 20);
    check("midrst_pops_before", pop_cyc.size(), 20);
    src.delete();
    fifo.in_empty = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_in_rd_en", fifo.in_rd_en, 0);
    check("midrst_out_wr_en", fifo.out_wr_en, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    fifo.in_empty = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) img[i] = 8'h7F;
    exp_q.delete(); add_golden(); load_src();
    run(N, 500, 0, 0, 0);
    compare("midrst_flat");
    extra = 0;
    repeat (20) begin
      @(negedge clock);
      if (fifo.out_wr_en || fifo.in_rd_en) extra++;
    end
    @(posedge clock);
    #1;
    check("midrst_extra_activity", extra, 0);

    // Back-to-back ramp then step with no gap.
    exp_q.delete();
    for (int i = 0; i < N; i++) img[i] = 8'(10 * (i % W));
    add_golden(); load_src();
    for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? 8'h00 : 8'hFF;
    add_golden(); load_src();
    run(2 * N, 1000, 0, 0, 0);
    compare("b2b");
    check("b2b_frame2_first_pop", (pop_cyc.size() > N) ?
          pop_cyc[N] - pop_cyc[0] : -1, N + W + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_filter.md
# sobel_filter

Streaming 3x3 Sobel edge-magnitude stage that sits directly downstream of the Gaussian blur stage in the lane-detection / Hough pipeline. It pops blurred 8-bit grayscale pixels from the blur output FIFO in raster order and pushes exactly one 8-bit gradient magnitude per input pixel into the FIFO feeding non-maximum suppression. Pixels on the one-pixel image border always produce 0.

## Interface
- IMG_WIDTH, default 720: pixels per row; legal range 4..2048.
- IMG_HEIGHT, default 540: rows per frame; legal range 3..2048.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted). Release is synchronous to clock.
- in_rd_en  output  1  pops in_dout this cycle. Reset value 0.
- in_empty  input  1  input FIFO empty.
- in_dout  input  8  blurred pixel; valid whenever in_empty=0.
- out_wr_en  output  1  pushes out_din this cycle. Reset value 0.
- out_full  input  1  output FIFO full.
- out_din  output  8  edge magnitude. Reset value 0x00.

## Operation
- Window storage: line buffer of 2*IMG_WIDTH+3 bytes, newest pixel at the tail. The window center is at index IMG_WIDTH+1. After pixel k is shifted in, the center is pixel k-IMG_WIDTH-1.
- Output register: one entry (out_data, out_valid). out_wr_en = out_valid & ~out_full. out_din = out_data.
- Advance condition (adv): the output slot is free (~out_valid | ~out_full) AND one of the following holds:
  - state is FILL or RUN and ~in_empty, or
  - state is FLUSH.
- On adv: shift the line buffer by one. The new byte is in_dout in FILL/RUN and 0x00 in FLUSH. in_rd_en = adv & (state != FLUSH).
- States:
  - FILL: consume pixels 0..IMG_WIDTH with no output. After IMG_WIDTH+1 pops, go to RUN.
  - RUN: each pop produces one output, computed from the post-shift window. After the pop of pixel IMG_WIDTH*IMG_HEIGHT-1, go to FLUSH.
  - FLUSH: shift IMG_WIDTH+1 zeros, producing one output each. After the last one, go to FILL and clear all counters.
- Center tracking: col and row counters of the center pixel. col wraps at IMG_WIDTH-1 and row increments on wrap.
- Border: if row==0, row==IMG_HEIGHT-1, col==0, or col==IMG_WIDTH-1, the output is 0. Stale data from a previous frame and flush zeros therefore never reach the output.
- Arithmetic, with window p[r][c], r and c in 0..2, r=0 the oldest row:
  - gx = (p[0][2] + 2p[1][2] + p[2][2]) - (p[0][0] + 2p[1][0] + p[2][0]), signed 11 bit.
  - gy = (p[2][0] + 2p[2][1] + p[2][2]) - (p[0][0] + 2p[0][1] + p[0][2]), signed 11 bit.
  - mag = (|gx| + |gy|) >> 1, 11 bit unsigned, maximum 1020.
  - out = mag > 255 ? 255 : mag[7:0].
- Reset mid-frame: all counters, out_valid and state return to FILL immediately. Line-buffer contents need not be cleared. The next frame begins at its pixel 0.

## Timing
- Throughput: one pixel per cycle when input is available and the output is not back-pressured.
- Latency: out_wr_en for pixel k-IMG_WIDTH-1 is asserted in the cycle after the pop of pixel k, if out_full=0.
- Simultaneous pop and push: when out_valid=1, out_full=0 and adv=1, the push of the old data and the load of new data happen in the same cycle, with no bubble.
- out_full held high: out_data stays stable. No pop occurs once out_valid=1. in_rd_en=0 while out_valid & out_full.
- Frame total: exactly IMG_WIDTH*IMG_HEIGHT pops and IMG_WIDTH*IMG_HEIGHT pushes.
- Frame boundary: the first pop of the next frame can occur in the cycle after the final FLUSH shift.

## Test plan
All scenarios use IMG_WIDTH=8 and IMG_HEIGHT=6 unless stated.
- Flat image, all pixels 0x7F, FIFO never empty or full -> 48 outputs, all 0x00; the first push occurs 10 cycles after the first pop.
- Horizontal ramp, pixel = 10*col -> interior outputs (rows 1-4, cols 1-6) = 40 (gx=80, gy=0); all border outputs = 0.
- Vertical step (cols 0-3 = 0x00, cols 4-7 = 0xFF) -> interior cols 3 and 4 = 255 (saturated from 510); other interior outputs = 0.
- Random image with in_empty and out_full each toggled pseudo-randomly at 30% -> output stream bit-exact with the golden model; no pop while the output is stalled; no push while out_full=1.
- reset pulsed low for 2 cycles after 20 pops of a frame, then a full new flat 0x7F frame -> all outputs after reset = 0x00; exactly 48 pushes after reset.
- Two back-to-back frames (ramp, then step) with no gap -> 96 pushes; frame 2 matches its standalone result exactly, with no frame-1 pixels leaking into its border rows.
